// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One result bit is produced per cycle on a 2*WIDTH-bit accumulator:
// shift-add for MULT/MULTU and restoring shift-subtract for DIV/DIVU.
// Signed operations run on magnitudes; the sign is applied in FIX.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset)
//   start      launch an operation (sampled only in IDLE)
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   srca       multiplicand / dividend (rs)
//   srcb       multiplier / divisor (rt)
//   hiwe/lowe  MTHI/MTLO write enables, honoured only in IDLE without start
//   wdata      MTHI/MTLO write data
//   busy       high while in CALC or FIX
//   done       one-cycle pulse in the first IDLE cycle after FIX
//   hi/lo      HI and LO registers
//   state_dbg  current FSM state (0 IDLE, 1 CALC, 2 FIX)
//
// Handshake: start is a request accepted on any rising edge where busy=0.
// There is no ready signal; while busy=1 start is ignored, so the hazard
// unit must stall the pipeline on (start | busy). Completion is signalled
// by done together with busy=0 and the new hi/lo values.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hiwe,
  input  logic             lowe,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_a_q, neg_a_d;   // dividend / multiplicand was negative
  logic                 neg_b_q, neg_b_d;   // divisor / multiplier was negative
  logic                 dz_q, dz_d;         // divide by zero
  logic [WIDTH-1:0]     opnd_q, opnd_d;     // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // Operand magnitudes at launch
  logic                 signed_op;
  logic                 sa, sb;
  logic [WIDTH-1:0]     abs_a, abs_b;

  // Datapath step
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic                 ge;
  logic [2*WIDTH-1:0]   div_next;

  // Sign-corrected results
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign signed_op = ~op[0];
  assign sa        = signed_op & srca[WIDTH-1];
  assign sb        = signed_op & srcb[WIDTH-1];
  assign abs_a     = sa ? (~srca + 1'b1) : srca;
  assign abs_b     = sb ? (~srcb + 1'b1) : srcb;

  // Multiply: accumulator is {partial product, remaining multiplier bits}.
  // The add carry is kept so the right shift brings it into the top bit.
  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: accumulator is {partial remainder, dividend/quotient bits}.
  // The shifted remainder needs one extra bit before the trial subtract.
  // With a zero divisor every trial succeeds, so the quotient fills with
  // ones and the remainder ends up as the dividend magnitude.
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, opnd_q};
  assign ge       = (rem_sh >= {1'b0, opnd_q});
  assign div_next = ge ? {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1}
                       : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Negating the remainder magnitude restores srca exactly for a zero
  // divisor, including the most-negative value whose magnitude wraps.
  assign prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = dz_q ? {WIDTH{1'b1}}
                  : ((neg_a_q ^ neg_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CALC;
          cnt_d    = CW'(WIDTH - 1);
          is_div_d = op[1];
          neg_a_d  = sa;
          neg_b_d  = sb;
          dz_d     = op[1] & (srcb == '0);
          if (op[1]) begin
            opnd_d = abs_b;
            acc_d  = {{WIDTH{1'b0}}, abs_a};
          end else begin
            opnd_d = abs_a;
            acc_d  = {{WIDTH{1'b0}}, abs_b};
          end
        end else begin
          // MTHI/MTLO only when no operation is being launched
          if (hiwe) hi_d = wdata;
          if (lowe) lo_d = wdata;
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed bench for muldiv_sequencer. Cycle n is the interval after rising
// edge n-1, where edge 0 samples start. Inputs change and outputs are
// sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srca, srcb;
  logic         hiwe, lowe;
  logic [W-1:0] wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W), .CW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .srca      (srca),
    .srcb      (srcb),
    .hiwe      (hiwe),
    .lowe      (lowe),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Launch one operation and watch 40 cycles. Optionally re-pulse start in
  // cycle restart_at, pulse lowe in cycle lowe_at, and assert hiwe together
  // with start. hi/lo must hold their old values while busy.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int restart_at, input int lowe_at,
                        input logic hiwe_with_start);
    logic [W-1:0] hi0, lo0, rh, rl;
    int nb, nd, dc, st33;
    logic stable, overlap;
    @(negedge clk);
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = o; srca = a; srcb = b;
    hiwe  = hiwe_with_start; wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    start = 1'b0; hiwe = 1'b0;
    srca = ~a; srcb = 32'h0000_0003;   // must not be resampled
    nb = 0; nd = 0; dc = 0; st33 = -1; stable = 1'b1; overlap = 1'b0;
    rh = '0; rl = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (busy) begin
        nb++;
        if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      end
      if (busy && done) overlap = 1'b1;
      if (done) begin
        nd++;
        if (dc == 0) begin
          dc = cyc; rh = hi; rl = lo;
        end
      end
      if (cyc == 33) st33 = int'(state_dbg);
      start = (cyc == restart_at);
      lowe  = (cyc == lowe_at);
      wdata = 32'hDEAD_0000 | 32'(cyc);
      @(posedge clk); #1;
    end
    start = 1'b0; lowe = 1'b0;
    chk({tag, " busy_cycles"}, 64'(nb), 64'd33);
    chk({tag, " done_pulses"}, 64'(nd), 64'd1);
    chk({tag, " done_cycle"},  64'(dc), 64'd34);
    chk({tag, " fix_state"},   64'(st33), 64'd2);
    chk({tag, " hold_hilo"},   64'(stable), 64'd1);
    chk({tag, " busy_done"},   64'(overlap), 64'd0);
    chk({tag, " hi"},          64'(rh), 64'(exp_hi));
    chk({tag, " lo"},          64'(rl), 64'(exp_lo));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [W-1:0] lo_keep;
    int nd, nb;
    reset = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    hiwe = 1'b0; lowe = 1'b0; wdata = '0;
    #3;
    chk("reset busy",  64'(busy), 64'd0);
    chk("reset done",  64'(done), 64'd0);
    chk("reset hi",    64'(hi), 64'd0);
    chk("reset lo",    64'(lo), 64'd0);
    chk("reset state", 64'(state_dbg), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Multiplies
    run_op("multu 7*6",   OP_MULTU, 32'd7,         32'd6,         32'h0000_0000, 32'd42,        0, 0, 1'b0);
    run_op("mult -3*5",   OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0, 1'b0);
    run_op("multu max^2", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 1'b0);

    // Divides
    run_op("div -7/2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 1'b0);
    run_op("div 7/-2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0, 1'b0);
    run_op("divu 100/7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        0, 0, 1'b0);
    run_op("divu x/0",    OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op("div -5/0",    OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op("div min/-1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0, 1'b0);

    // Restart in cycle 10 and MTLO in cycle 5 are both ignored
    run_op("multu 3*4 restart", OP_MULTU, 32'd3, 32'd4, 32'h0000_0000, 32'd12, 10, 5, 1'b0);

    // MTHI in IDLE
    @(negedge clk);
    lo_keep = lo;
    hiwe = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hiwe = 1'b0;
    chk("mthi hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mthi lo", 64'(lo), 64'(lo_keep));

    // MTHI and MTLO together
    @(negedge clk);
    hiwe = 1'b1; lowe = 1'b1; wdata = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    hiwe = 1'b0; lowe = 1'b0;
    chk("mthi+mtlo hi", 64'(hi), 64'h0F0F_0F0F);
    chk("mthi+mtlo lo", 64'(lo), 64'h0F0F_0F0F);

    // hiwe with start: write dropped (hold check covers hi during busy)
    run_op("multu 2*3 hiwe", OP_MULTU, 32'd2, 32'd3, 32'h0000_0000, 32'd6, 0, 0, 1'b1);

    // Reset in cycle 15 of a running operation
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; srca = 32'd9; srcb = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    chk("pre-abort busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort busy",  64'(busy), 64'd0);
    chk("abort done",  64'(done), 64'd0);
    chk("abort hi",    64'(hi), 64'd0);
    chk("abort lo",    64'(lo), 64'd0);
    chk("abort state", 64'(state_dbg), 64'd0);
    @(negedge clk); reset = 1'b1;
    nd = 0; nb = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (busy) nb++;
    end
    chk("post-abort done_pulses", 64'(nd), 64'd0);
    chk("post-abort busy_cycles", 64'(nb), 64'd0);
    chk("post-abort lo", 64'(lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
